// File: rtl/step_pulse_gen.sv
// Step clock-enable generator: debounced single-step key or fixed-rate auto-run,
// with a 16-bit count of issued steps.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 12500000
) (
  input  logic        CLOCK_50,
  input  logic        Resetn,
  input  logic        KeyIn,
  input  logic        RunMode,
  output logic        Step,
  output logic        Pressed,
  output logic [15:0] StepCount
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(RUN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_raw;
  logic            w_rise;
  logic            w_rate_term;
  logic            w_step_set;
  logic            w_rate_run;
  logic            r_pressed;
  logic            r_pressed_d;
  logic [DW-1:0]   r_deb_cnt;
  logic [RW-1:0]   r_rate_cnt;
  logic            r_step;
  logic [15:0]     r_step_count;

  assign w_raw       = ~KeyIn;
  assign w_rise      = r_pressed & ~r_pressed_d;
  assign w_rate_term = (r_rate_cnt == RATE_LAST);

  assign Step      = r_step;
  assign Pressed   = r_pressed;
  assign StepCount = r_step_count;

  // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_pressed   <= 1'b0;
      r_pressed_d <= 1'b0;
      r_deb_cnt   <= '0;
    end else begin
      r_pressed_d <= r_pressed;
      if (w_raw == r_pressed) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_pressed <= w_raw;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (RunMode)     w_state_next = S_RUN;
        else if (w_rise) w_state_next = S_HELD;
      end
      S_HELD: begin
        if (RunMode)         w_state_next = S_RUN;
        else if (!r_pressed) w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (!RunMode) w_state_next = r_pressed ? S_HELD : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Run mode entering in the same cycle as a key edge suppresses the manual step.
  always_comb begin
    w_step_set = 1'b0;
    w_rate_run = 1'b0;
    case (r_state)
      S_IDLE: w_step_set = ~RunMode & w_rise;
      S_RUN: begin
        if (RunMode) begin
          w_rate_run = 1'b1;
          w_step_set = w_rate_term;
        end
      end
      default: begin
        w_step_set = 1'b0;
        w_rate_run = 1'b0;
      end
    endcase
  end

  // Rate counter is held at zero outside RUN so every entry starts a full period.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_rate_cnt   <= '0;
      r_step       <= 1'b0;
      r_step_count <= '0;
    end else begin
      if (w_rate_run) begin
        r_rate_cnt <= w_rate_term ? '0 : r_rate_cnt + RW'(1);
      end else begin
        r_rate_cnt <= '0;
      end
      r_step <= w_step_set;
      if (w_step_set) begin
        r_step_count <= r_step_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Single-step / auto-run clock-enable generator that sits directly upstream of the processor's step input. It takes the already-synchronized step key, debounces it, and emits exactly one single-cycle `Step` pulse per press. When run mode is selected, it instead emits `Step` pulses periodically at a fixed rate. It also keeps a 16-bit count of issued steps for the display selector.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles the key must differ from the debounced level before the level flips (10 ms at 50 MHz); legal range ≥ 2.
- `RUN_DIV`, default 12500000: cycles between `Step` pulses in run mode (4 Hz); legal range ≥ 2.

Ports:
- `CLOCK_50`  in  1: sole clock; all state updates on its rising edge.
- `Resetn`  in  1: asynchronous, active-low reset.
- `KeyIn`  in  1: step key, already synchronized to `CLOCK_50`; active-low (0 = pressed).
- `RunMode`  in  1: level from a switch; 1 = auto-run, 0 = single-step. Synchronized externally.
- `Step`  out  1: registered one-cycle enable pulse to the processor.
- `Pressed`  out  1: registered debounced key level (1 = pressed).
- `StepCount`  out  16: registered count of `Step` pulses issued.

## Operation
- **Reset values.** `Step`=0, `Pressed`=0, `StepCount`=0, debounce counter=0, rate counter=0, state=IDLE.
- **Debouncer.**
  - Let raw = ~`KeyIn`.
  - If raw == `Pressed`: clear the debounce counter.
  - Otherwise increment the counter. On the cycle the counter equals `DEBOUNCE_CYCLES`-1 with raw still differing, set `Pressed` <= raw and clear the counter.
  - Any cycle with raw == `Pressed` restarts the count (glitch rejection).
  - The debouncer runs in all states.
- **Step FSM states.** IDLE, HELD, RUN.
- **IDLE:**
  - `RunMode`=1: go to RUN with the rate counter cleared. No step is issued this cycle.
  - Else, on a rising edge of `Pressed` (registered 0 → 1): pulse `Step`, go to HELD.
- **HELD:**
  - `Pressed`=0: go to IDLE.
  - `RunMode`=1: go to RUN; this takes priority over release.
  - No `Step` pulses are issued in HELD.
- **RUN:**
  - The rate counter increments each cycle.
  - When it equals `RUN_DIV`-1: pulse `Step` and wrap the counter to 0.
  - The key is ignored.
  - `RunMode`=0: clear the rate counter. Go to HELD if `Pressed`=1, else IDLE. No step is issued on the exit cycle, even if the counter was at terminal count.
- **StepCount.** Increments by 1 in the same cycle `Step` is driven high, i.e. the registered value updates together with `Step`. Modulo 2^16: 0xFFFF → 0x0000.
- **Pulse width.** `Step` is never high on two consecutive cycles for any legal parameter values.
- **Reset mid-operation.** Asynchronously forces all reset values. A key held through reset release must first debounce high before `Pressed` rises. That rising edge then issues one `Step`.

## Timing
- **Debounce latency.** Raw first sampled pressed at edge t0 and held: `Pressed`=1 after edge t0+`DEBOUNCE_CYCLES`-1. Release is symmetric.
- **Press-to-step latency.** `Step`=1 for exactly the one cycle after `Pressed` rises, i.e. after edge t0+`DEBOUNCE_CYCLES`. Total latency is `DEBOUNCE_CYCLES`+1 edges from first pressed sample.
- **Run-mode spacing.**
  - First `Step` comes `RUN_DIV` cycles after the RUN-entry edge.
  - Subsequent pulses are exactly `RUN_DIV` cycles apart.
- **Simultaneous events.**
  - `RunMode` rising in the same cycle as a `Pressed` edge in IDLE: RUN wins, no manual step.
  - Pressed edge during RUN: no effect.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `RUN_DIV`=5.
1. **Reset.** `Resetn`=0 mid-count with `KeyIn`=0 → all outputs 0 immediately, asynchronously. Release with key held → `Pressed` rises 3 edges later, then one `Step`, `StepCount`=1.
2. **Clean press.** `KeyIn` low for 20 cycles, then high → exactly one `Step` 4 edges after first low sample. `Pressed` falls 3 edges after release. `StepCount`=1.
3. **Bounce rejection.** `KeyIn` pattern 0,0,0,1,0,0,1,0 then high → `Pressed` stays 0, no `Step`, `StepCount`=0.
4. **Run mode.** `RunMode`=1 for 23 cycles → `Step` on cycles 5, 10, 15, 20 after entry; `StepCount`=4. Key presses during the window add no steps.
5. **Run exit with key held.** Key held, `RunMode` 1 → 0 → state HELD, no `Step` until release plus a new debounced press.
6. **Wrap.** Force 65536 steps in run mode → `StepCount` goes 0xFFFF → 0x0000 on the 65536th pulse.
